// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle FETCH/DECODE/EXEC/WB sequencer for an RV32I subset (OP, OP-IMM, BEQ/BNE, LUI).
// Define SEQ_CTRL_BARREL_SHIFT_EN for single-cycle shifts; otherwise shifts run one bit per EXEC cycle.
module seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pc,
    output logic        halt
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [31:0] r_imm;
    logic [4:0]  r_cnt;
    logic        r_taken;
    logic        r_halt;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;

    logic [4:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_isOp;
    logic        w_isOpImm;
    logic        w_isBranch;
    logic        w_isLui;
    logic        w_isShift;
    logic        w_legal;
    logic        w_taken;
    logic        w_writes;
    logic        w_execDone;
    logic [31:0] w_immI;
    logic [31:0] w_immB;
    logic [31:0] w_immU;
    logic [31:0] w_opB;
    logic [31:0] w_addSub;
    logic [31:0] w_step;
    logic [31:0] w_shiftRes;
    logic [31:0] w_result;

    assign w_opcode   = r_inst[6:2];
    assign w_funct3   = r_inst[14:12];
    assign w_funct7   = r_inst[31:25];
    assign w_isOp     = (w_opcode == 5'b01100);
    assign w_isOpImm  = (w_opcode == 5'b00100);
    assign w_isBranch = (w_opcode == 5'b11000);
    assign w_isLui    = (w_opcode == 5'b01101);
    assign w_isShift  = (w_isOp || w_isOpImm) && ((w_funct3 == 3'b001) || (w_funct3 == 3'b101));

    assign w_immI = {{20{r_inst[31]}}, r_inst[31:20]};
    assign w_immB = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
    assign w_immU = {r_inst[31:12], 12'h000};

    always_comb begin
        w_legal = 1'b0;
        if (r_inst[1:0] == 2'b11) begin
            case (w_opcode)
                5'b01100: begin
                    case (w_funct3)
                        3'b000, 3'b101: w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                        3'b001:         w_legal = (w_funct7 == 7'b0000000);
                        default:        w_legal = 1'b0;
                    endcase
                end
                5'b00100: begin
                    case (w_funct3)
                        3'b000:  w_legal = 1'b1;
                        3'b001:  w_legal = (w_funct7 == 7'b0000000);
                        3'b101:  w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                        default: w_legal = 1'b0;
                    endcase
                end
                5'b11000: w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001);
                5'b01101: w_legal = 1'b1;
                default:  w_legal = 1'b0;
            endcase
        end
    end

    // Bit 30 selects SUB for OP and the arithmetic variant for right shifts.
    assign w_opB    = w_isOpImm ? r_imm : r_op2;
    assign w_addSub = (w_isOp && r_inst[30]) ? (r_op1 - w_opB) : (r_op1 + w_opB);
    assign w_taken  = w_funct3[0] ? (r_op1 != r_op2) : (r_op1 == r_op2);
    assign w_writes = (w_isOp || w_isOpImm || w_isLui) && (r_inst[11:7] != 5'd0);

`ifdef SEQ_CTRL_BARREL_SHIFT_EN
    logic [31:0] w_sra;
    assign w_sra      = $signed(r_op1) >>> r_cnt;
    assign w_shiftRes = (w_funct3 == 3'b001) ? (r_op1 << r_cnt) : (r_inst[30] ? w_sra : (r_op1 >> r_cnt));
    assign w_step     = r_op1;
    assign w_execDone = 1'b1;
`else
    // r_op1 doubles as the shift register; the last bit is taken combinationally on the final EXEC cycle.
    assign w_step     = (w_funct3 == 3'b001) ? {r_op1[30:0], 1'b0} : {r_inst[30] & r_op1[31], r_op1[31:1]};
    assign w_shiftRes = (r_cnt == 5'd0) ? r_op1 : w_step;
    assign w_execDone = !w_isShift || (r_cnt <= 5'd1);
`endif

    assign w_result = w_isLui ? r_imm : (w_isShift ? w_shiftRes : w_addSub);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_inst     <= 32'h0;
            r_op1      <= 32'h0;
            r_op2      <= 32'h0;
            r_imm      <= 32'h0;
            r_cnt      <= 5'd0;
            r_taken    <= 1'b0;
            r_halt     <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'h0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_inst  <= imem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_op1   <= rf_rdata1;
                        r_op2   <= rf_rdata2;
                        r_imm   <= w_isOpImm ? w_immI : (w_isBranch ? w_immB : w_immU);
                        r_cnt   <= w_isOp ? rf_rdata2[4:0] : r_inst[24:20];
                        r_state <= S_EXEC;
                    end else begin
                        r_halt  <= 1'b1;
                        r_state <= S_HALT;
                    end
                end
                S_EXEC: begin
                    if (w_execDone) begin
                        r_rf_we    <= w_writes;
                        r_rf_waddr <= r_inst[11:7];
                        r_rf_wdata <= w_result;
                        r_taken    <= w_isBranch && w_taken;
                        r_state    <= S_WB;
                    end else begin
                        r_op1 <= w_step;
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_WB: begin
                    r_rf_we <= 1'b0;
                    r_pc    <= r_taken ? (r_pc + r_imm) : (r_pc + 32'd4);
                    r_state <= S_FETCH;
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign rf_raddr1 = r_inst[19:15];
    assign rf_raddr2 = r_inst[24:20];
    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
    assign pc        = r_pc;
    assign halt      = r_halt;

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Multi-cycle sequencer for the RV32I subset core: OP (ADD/SUB/SLL/SRL/SRA), OP-IMM (ADDI/SLLI/SRLI/SRAI), BRANCH (BEQ/BNE) and LUI. It owns the PC and fetches over a req/ack instruction port. It also decodes, drives the register file read and write ports, and runs the ALU/shifter, one instruction at a time. Any encoding outside the subset halts the core.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- rf_raddr1 / rf_raddr2  out  5  rs1 / rs2 (inst[19:15] / inst[24:20])
- rf_rdata1 / rf_rdata2  in  32  combinational read data
- rf_we  out  1  register write strobe
- rf_waddr  out  5  rd
- rf_wdata  out  32  write data
- pc  out  32  current PC
- halt  out  1  illegal instruction seen; sticky until reset

## Operation
- States: FETCH, DECODE, EXEC, WB, HALT. Reset -> FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1: latch imem_rdata into inst -> DECODE.
- DECODE:
  - Check legality.
    - inst[1:0]==2'b11.
    - inst[6:2] in {01100, 00100, 11000, 01101}.
    - OP: funct3 000 requires funct7 0000000/0100000; 001 requires funct7 0000000; 101 requires funct7 0000000/0100000; other funct3 illegal.
    - OP-IMM: funct3 000 (any funct7); 001 requires funct7 0000000; 101 requires 0000000/0100000; others illegal.
    - BRANCH: funct3 000/001 only.
  - Legal: latch rs1/rs2 data and the decoded immediate -> EXEC. Illegal -> HALT.
- EXEC: compute result or branch decision -> WB. Shifts may stay multiple cycles (see Configuration).
- WB:
  - rf_we=1 for OP, OP-IMM and LUI when rd!=0. rf_we stays 0 for rd=0 and for BRANCH.
  - pc <= taken ? pc+B-imm : pc+4 -> FETCH.
  - Taken means BEQ with equal operands or BNE with unequal operands.
- Arithmetic:
  - 32-bit wrap-around add/sub; carry discarded.
  - I-imm and B-imm sign-extended; B-imm bit 0 = 0.
  - LUI result = {inst[31:12], 12'h0}.
  - Shift amount = rs2[4:0] (OP) or inst[24:20] (OP-IMM). SRA/SRAI replicate bit 31.
- HALT: absorbing.
  - halt=1, imem_req=0, rf_we=0, pc frozen at the illegal instruction's address.
- imem_ack outside FETCH is ignored.

## Timing
- Reset values (asynchronous): state=FETCH, pc=RESET_PC, halt=0, rf_we=0, rf_waddr=0, rf_wdata=0, inst=0.
- imem_req is combinational from state, so it is 1 in the first cycle after reset release.
- imem_addr is held stable while imem_req=1 and imem_ack=0. A zero-wait-state memory acks in the same cycle as the request.
- Non-shift instruction with zero-wait fetch: 4 cycles (FETCH, DECODE, EXEC, WB). Each fetch wait state adds 1.
- rf_we, rf_waddr and rf_wdata are valid only in the WB cycle. The register file writes on that cycle's rising edge.
- The pc update is visible in the cycle after WB, which is the next FETCH.
- Illegal instruction: halt rises in the cycle after DECODE.
- Reset mid-instruction: all in-flight state is discarded, and an ack arriving in the reset cycle is ignored. Fetch restarts at RESET_PC.

## Configuration
- SEQ_CTRL_BARREL_SHIFT_EN defined: shifts complete in one EXEC cycle, like all other operations.
- Undefined: serial shifter, one bit per EXEC cycle, using a 5-bit down-counter loaded in DECODE.
  - EXEC lasts max(1, shamt) cycles.
  - shamt=0 takes 1 cycle and passes rs1 through.
  - Non-shift operations are unaffected.
- Results are identical in both builds; only cycle count differs.

## Test plan
- Reset, then zero-wait memory holding ADDI x1,x0,5 (0x00500093) -> imem_addr=0 in cycle 1; WB in cycle 4 with rf_waddr=1, rf_wdata=5; pc=4 in cycle 5.
- LUI x2,0x12345 followed by SUB x3,x2,x1 with x1=5 -> x2=0x12345000; x3=0x12344FFB.
- SRAI x4,x5,31 with x5=0x80000000 -> x4=0xFFFFFFFF.
  - Serial build: 31 EXEC cycles, 34 total.
  - Barrel build: 4 total.
- Branches at pc=0x10 with x1=x2 -> BEQ offset -8: pc=0x08. BNE: pc=0x14 with rf_we=0.
- ADD x0,x1,x1 -> rf_we stays 0.
- Fetch with 3 wait states -> imem_addr stable for 4 cycles; instruction takes 7 cycles.
- Illegal word 0x00000003 (load) at pc=0x20 -> halt=1 from the cycle after DECODE, imem_req=0, pc=0x20.
- Assert reset while in HALT -> halt=0 and fetch resumes at RESET_PC.
